// File: rtl/qdec_mbank_line_buffer.sv
// ----------------------------------------------------------------------------
// qdec_mbank_line_buffer
//
// N-bank circular line buffer between the CABAC context FSM (syntax writer)
// and the downstream CTU consumers (syntax reader). The writer fills one bank
// per CTU and commits it. The reader drains committed banks in commit order
// and releases them. Up to NBANK CTUs can sit between producer and consumer.
//
// Parameters
//   DATA_W  syntax word width
//   DEPTH   words per bank
//   NBANK   bank count, 2..8 (need not be a power of two)
//   AW/BW/CW derived address / bank index / occupancy widths
//
// Ports
//   clk, rst         single clock, synchronous active-high reset
//   lb_waddr/lb_din/lb_we    word write into the writer-owned bank
//   wr_commit        pulse, writer bank complete
//   wr_bank_avail    writer owns a bank (occupancy < NBANK)
//   wr_bank_idx      bank owned by the writer
//   lb_raddr/lb_re   word read from the reader-owned bank
//   lb_dout/lb_dout_vld      read data and its single-cycle valid
//   rd_release       pulse, reader finished with its bank
//   rd_bank_avail    reader owns a committed bank (occupancy > 0)
//   rd_bank_idx      bank owned by the reader
//   bank_cnt         committed banks, 0..NBANK
//   overflow_err     sticky, write or commit while full
//   underflow_err    sticky, release while empty
//   err_clr          clears both sticky flags (a same-cycle error wins)
//
// Build option
//   QDEC_LB_OREG_EN  adds an output register after the array read, making the
//                    read latency 2 cycles instead of 1. Throughput unchanged.
// ----------------------------------------------------------------------------
module qdec_mbank_line_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4096,
    parameter int NBANK  = 2,
    parameter int AW     = $clog2(DEPTH),
    parameter int BW     = $clog2(NBANK),
    parameter int CW     = $clog2(NBANK + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     lb_waddr,
    input  logic [DATA_W-1:0] lb_din,
    input  logic              lb_we,
    input  logic              wr_commit,
    output logic              wr_bank_avail,
    output logic [BW-1:0]     wr_bank_idx,
    input  logic [AW-1:0]     lb_raddr,
    input  logic              lb_re,
    output logic [DATA_W-1:0] lb_dout,
    output logic              lb_dout_vld,
    input  logic              rd_release,
    output logic              rd_bank_avail,
    output logic [BW-1:0]     rd_bank_idx,
    output logic [CW-1:0]     bank_cnt,
    output logic              overflow_err,
    output logic              underflow_err,
    input  logic              err_clr
);

    localparam int              PW        = $clog2(NBANK * DEPTH);
    localparam logic [BW-1:0]   LAST_BANK = BW'(NBANK - 1);
    localparam logic [CW-1:0]   FULL_CNT  = CW'(NBANK);

    // Bank pointers wrap explicitly so NBANK need not be a power of two.
    function automatic logic [BW-1:0] bank_inc(input logic [BW-1:0] p);
        return (p == LAST_BANK) ? '0 : p + BW'(1);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [BW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [BW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              vld_q, vld_d;
`ifdef QDEC_LB_OREG_EN
    logic [DATA_W-1:0] oreg_q, oreg_d;
    logic              oreg_vld_q, oreg_vld_d;
`endif

    // Storage array, not reset: stale bank contents are never visible because
    // a bank is only readable after the writer has committed it.
    logic [DATA_W-1:0] mem [NBANK*DEPTH];

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic          wr_avail;
    logic          rd_avail;
    logic          wr_en;
    logic          rd_en;
    logic          commit_ok;
    logic          release_ok;
    logic [PW-1:0] wr_phys;
    logic [PW-1:0] rd_phys;
    logic [DATA_W-1:0] rd_word;

    always_comb begin
        // Availability comes from registered occupancy only, so no
        // combinational path from the strobes to the avail outputs.
        wr_avail   = (cnt_q != FULL_CNT);
        rd_avail   = (cnt_q != '0);
        wr_en      = lb_we & wr_avail;
        rd_en      = lb_re & rd_avail;
        commit_ok  = wr_commit & wr_avail;
        release_ok = rd_release & rd_avail;
        wr_phys    = PW'(wr_ptr_q) * PW'(DEPTH) + PW'(lb_waddr);
        rd_phys    = PW'(rd_ptr_q) * PW'(DEPTH) + PW'(lb_raddr);
        rd_word    = mem[rd_phys];
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        if (commit_ok) begin
            wr_ptr_d = bank_inc(wr_ptr_q);
        end
        if (release_ok) begin
            rd_ptr_d = bank_inc(rd_ptr_q);
        end

        // At full, a release frees a bank this cycle but the commit was
        // already rejected on registered occupancy, so only the release counts.
        case ({commit_ok, release_ok})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (err_clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        // Set after clear so a same-cycle error event keeps the flag up.
        if ((lb_we | wr_commit) & ~wr_avail) begin
            ovf_d = 1'b1;
        end
        if (rd_release & ~rd_avail) begin
            unf_d = 1'b1;
        end
    end

    always_comb begin
        // Read data holds between accepted reads; valid is a one-cycle pulse.
        dout_d = rd_en ? rd_word : dout_q;
        vld_d  = rd_en;
`ifdef QDEC_LB_OREG_EN
        oreg_d     = vld_q ? dout_q : oreg_q;
        oreg_vld_d = vld_q;
`endif
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            dout_q   <= '0;
            vld_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            dout_q   <= dout_d;
            vld_q    <= vld_d;
        end
    end

`ifdef QDEC_LB_OREG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            oreg_q     <= '0;
            oreg_vld_q <= 1'b0;
        end else begin
            oreg_q     <= oreg_d;
            oreg_vld_q <= oreg_vld_d;
        end
    end
`endif

    // Array write port, kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_phys] <= lb_din;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wr_bank_avail = wr_avail;
    assign rd_bank_avail = rd_avail;
    assign wr_bank_idx   = wr_ptr_q;
    assign rd_bank_idx   = rd_ptr_q;
    assign bank_cnt      = cnt_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;
`ifdef QDEC_LB_OREG_EN
    assign lb_dout       = oreg_q;
    assign lb_dout_vld   = oreg_vld_q;
`else
    assign lb_dout       = dout_q;
    assign lb_dout_vld   = vld_q;
`endif

endmodule

// File: doc/qdec_mbank_line_buffer.md
# qdec_mbank_line_buffer

Parametrised N-bank circular line buffer between the CABAC context FSM (syntax writer) and downstream CTU consumers (syntax reader), generalising the two-bank ping-pong line buffer. The writer fills one bank per CTU and commits it; the reader drains committed banks in order and releases them. Producer and consumer are decoupled by up to NBANK CTUs. Occupancy, overflow and underflow are reported explicitly.

## Interface
- DATA_W, 8, syntax word width
- DEPTH, 4096, words per bank
- NBANK, 2, bank count, 2..8 (not required to be a power of two)
- AW, $clog2(DEPTH), derived address width
- BW, $clog2(NBANK), derived bank index width
- CW, $clog2(NBANK+1), derived occupancy width

Ports:
- clk  in  1  single clock
- rst  in  1  reset, synchronous, active-high
- lb_waddr  in  AW  write address within writer bank
- lb_din  in  DATA_W  write data
- lb_we  in  1  write strobe
- wr_commit  in  1  pulse: current writer bank complete (CTU done)
- wr_bank_avail  out  1  writer owns a bank (occupancy < NBANK)
- wr_bank_idx  out  BW  bank currently owned by writer
- lb_raddr  in  AW  read address within reader bank
- lb_re  in  1  read strobe
- lb_dout  out  DATA_W  read data
- lb_dout_vld  out  1  lb_dout valid this cycle
- rd_release  in  1  pulse: reader finished with current bank
- rd_bank_avail  out  1  reader owns a committed bank (occupancy > 0)
- rd_bank_idx  out  BW  bank currently owned by reader
- bank_cnt  out  CW  committed banks, 0..NBANK
- overflow_err  out  1  sticky: write or commit while full
- underflow_err  out  1  sticky: release while empty
- err_clr  in  1  clears both sticky flags

## Operation
- Storage: single array of NBANK*DEPTH words, physical address bank*DEPTH + addr. Contents not reset.
- State registers: wr_ptr, rd_ptr (BW bits, wrap NBANK-1 -> 0 explicitly), cnt (CW bits).
- wr_bank_avail = (cnt != NBANK); rd_bank_avail = (cnt != 0); both decoded from registers only.
- Writer bank = wr_ptr, reader bank = rd_ptr. They coincide only when cnt==0 (reader owns nothing) or cnt==NBANK (writer owns nothing), so reader/writer never share a live bank.
- Write: lb_we & wr_bank_avail stores lb_din at {wr_ptr, lb_waddr}. lb_we & !wr_bank_avail: write dropped, overflow_err set.
- Commit: wr_commit & wr_bank_avail: wr_ptr advances, cnt+1. wr_commit while full: ignored, overflow_err set.
- Release: rd_release & rd_bank_avail: rd_ptr advances, cnt-1. rd_release while empty: ignored, underflow_err set.
- Simultaneous valid commit and release: both pointers advance, cnt unchanged. When cnt==NBANK, release is valid and commit is not: commit is ignored and flagged even though a bank frees that cycle.
- Read: lb_re & rd_bank_avail reads {rd_ptr, lb_raddr}. lb_re while empty: no access, lb_dout holds, lb_dout_vld stays 0, no error.
- err_clr has priority below set: a same-cycle error event leaves the flag set.
- Reset (any time, including mid-CTU): pointers 0, cnt 0; all committed data discarded.

## Timing
- Reset values: lb_dout 0, lb_dout_vld 0, wr_bank_avail 1, rd_bank_avail 0, wr_bank_idx 0, rd_bank_idx 0, bank_cnt 0, overflow_err 0, underflow_err 0.
- Write and commit in the same cycle: the write lands in the bank being committed.
- Read and release in the same cycle: the read uses the bank being released.
- Commit/release effects are visible on avail/idx/cnt outputs the following cycle.
- Read latency 1 cycle (see Configuration): lb_re at cycle t -> lb_dout/lb_dout_vld at t+1. lb_dout_vld is a single-cycle pulse per accepted read. Back-to-back reads are supported at full rate.
- Write-to-read of the same word is possible only after commit, so read-during-write ordering is not required.

## Configuration
- QDEC_LB_OREG_EN defined: extra output register after the array read; read latency 2 cycles, lb_dout_vld delayed accordingly. Throughput stays one read per cycle; the extra register resets to 0.
- Not defined: read latency 1 cycle as above.

## Test plan
Parameters for all cases: NBANK=3, DEPTH=16, DATA_W=8, QDEC_LB_OREG_EN undefined unless stated.
- Basic: write addr 5 = 0xA5, commit, read addr 5 -> lb_dout 0xA5 with lb_dout_vld at t+1; bank_cnt goes 0->1; rd_bank_idx 0, wr_bank_idx 1.
- Fill and overflow: commit 3 banks (bank b addr 0 = 0x10+b) -> wr_bank_avail 0, bank_cnt 3. Write 0xFF and commit again -> both ignored, overflow_err 1. Read back banks 0,1,2 in order via release -> 0x10, 0x11, 0x12. Bank 2 is not overwritten.
- Wrap: 5 commit/release cycles -> pointers go 0,1,2,0,1; data tag per CTU read back correctly on each.
- Simultaneous commit+release at cnt=1 -> cnt stays 1, both idx advance; same-cycle write lands in the committed bank.
- Underflow and clear: release at cnt=0 -> underflow_err 1, cnt 0. lb_re at cnt=0 -> lb_dout_vld 0. err_clr -> flag 0. Reset mid-fill at cnt=2 -> all outputs return to reset values.
- With QDEC_LB_OREG_EN defined: repeat basic case -> 0xA5 valid at t+2. Back-to-back reads of addr 0..3 return in order at 1 word per cycle.
